// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO pair.
// Optional MULDIV_MUL_MULTICYCLE_EN registers the product and commits it a cycle later.
module hilo_muldiv #(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluopE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        stallE,
    input  logic        cancelE,
    output logic        muldiv_stallE,
    output logic [31:0] hilo_outE,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [7:0] ALUOP_MFHI  = 8'h10;
    localparam logic [7:0] ALUOP_MTHI  = 8'h11;
    localparam logic [7:0] ALUOP_MFLO  = 8'h12;
    localparam logic [7:0] ALUOP_MTLO  = 8'h13;
    localparam logic [7:0] ALUOP_MULT  = 8'h18;
    localparam logic [7:0] ALUOP_MULTU = 8'h19;
    localparam logic [7:0] ALUOP_DIV   = 8'h1a;
    localparam logic [7:0] ALUOP_DIVU  = 8'h1b;

    localparam int unsigned CntW = $clog2(DIV_ITERS + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone, StMulDone} state_e;

    state_e          state_q;
    logic [31:0]     hi_q, lo_q;
    logic [31:0]     rem_q, quo_q, dvs_q;
    logic            sa_q, sb_q, dz_q;
    logic [CntW-1:0] cnt_q;
`ifdef MULDIV_MUL_MULTICYCLE_EN
    logic [63:0]     prod_q;
`endif

    logic        is_div, is_mul, div_signed, mul_signed, start_div;
    logic [31:0] a_mag, b_mag;
    logic [63:0] mul_a, mul_b, prod;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub, rem_d, quo_d;
    logic [31:0] div_hi, div_lo;

    assign is_div     = (aluopE == ALUOP_DIV) || (aluopE == ALUOP_DIVU);
    assign is_mul     = (aluopE == ALUOP_MULT) || (aluopE == ALUOP_MULTU);
    assign div_signed = (aluopE == ALUOP_DIV);
    assign mul_signed = (aluopE == ALUOP_MULT);
    assign start_div  = is_div && !cancelE;

    assign a_mag = (div_signed && srcaE[31]) ? -srcaE : srcaE;
    assign b_mag = (div_signed && srcbE[31]) ? -srcbE : srcbE;

    // Low 64 bits of a 64x64 product of extended operands give the exact signed/unsigned result.
    assign mul_a = {(mul_signed ? {32{srcaE[31]}} : 32'h0), srcaE};
    assign mul_b = {(mul_signed ? {32{srcbE[31]}} : 32'h0), srcbE};
    assign prod  = mul_a * mul_b;

    // One restoring step; the true difference always fits in 32 bits when it is kept.
    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_ge    = rem_shift >= {1'b0, dvs_q};
    assign rem_sub   = rem_shift[31:0] - dvs_q;
    assign rem_d     = rem_ge ? rem_sub : rem_shift[31:0];
    assign quo_d     = {quo_q[30:0], rem_ge};

    // With a zero divisor the remainder ends as the dividend magnitude, so HI needs no special case.
    assign div_lo = dz_q ? 32'hffff_ffff : ((sa_q ^ sb_q) ? -quo_q : quo_q);
    assign div_hi = sa_q ? -rem_q : rem_q;

    always_comb begin
        muldiv_stallE = 1'b0;
        unique case (state_q)
            StIdle: begin
                muldiv_stallE = start_div;
`ifdef MULDIV_MUL_MULTICYCLE_EN
                if (is_mul && !cancelE) muldiv_stallE = 1'b1;
`endif
            end
            StBusy:  muldiv_stallE = 1'b1;
            default: muldiv_stallE = 1'b0;
        endcase
    end

    always_comb begin
        hilo_outE = 32'h0;
        if (aluopE == ALUOP_MFHI) hilo_outE = hi_q;
        else if (aluopE == ALUOP_MFLO) hilo_outE = lo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            rem_q   <= 32'h0;
            quo_q   <= 32'h0;
            dvs_q   <= 32'h0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef MULDIV_MUL_MULTICYCLE_EN
            prod_q  <= 64'h0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_div) begin
                        rem_q   <= 32'h0;
                        quo_q   <= a_mag;
                        dvs_q   <= b_mag;
                        sa_q    <= div_signed && srcaE[31];
                        sb_q    <= div_signed && srcbE[31];
                        dz_q    <= (srcbE == 32'h0);
                        cnt_q   <= '0;
                        state_q <= StBusy;
`ifdef MULDIV_MUL_MULTICYCLE_EN
                    end else if (is_mul && !cancelE) begin
                        prod_q  <= prod;
                        state_q <= StMulDone;
`endif
                    end else if (!stallE && !cancelE) begin
                        if (aluopE == ALUOP_MTHI) hi_q <= srcaE;
                        if (aluopE == ALUOP_MTLO) lo_q <= srcaE;
`ifndef MULDIV_MUL_MULTICYCLE_EN
                        if (is_mul) {hi_q, lo_q} <= prod;
`endif
                    end
                end
                StBusy: begin
                    if (cancelE) begin
                        state_q <= StIdle;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == CntW'(DIV_ITERS - 1)) state_q <= StDone;
                    end
                end
                StDone: begin
                    if (cancelE) begin
                        state_q <= StIdle;
                    end else if (!stallE) begin
                        hi_q    <= div_hi;
                        lo_q    <= div_lo;
                        state_q <= StIdle;
                    end
                end
`ifdef MULDIV_MUL_MULTICYCLE_EN
                StMulDone: begin
                    if (cancelE) begin
                        state_q <= StIdle;
                    end else if (!stallE) begin
                        {hi_q, lo_q} <= prod_q;
                        state_q      <= StIdle;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected MFHI/MFLO values are queued at issue time
// and a negedge monitor pops and compares them whenever a read leaves E.
module tb_hilo_muldiv;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1a;
    localparam logic [7:0] OP_DIVU  = 8'h1b;

`ifdef MULDIV_MUL_MULTICYCLE_EN
    localparam int MulStalls = 1;
`else
    localparam int MulStalls = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluopE;
    logic [31:0] srcaE, srcbE;
    logic        ext_stall, cancelE, stallE;
    logic        muldiv_stallE;
    logic [31:0] hilo_outE, hi_o, lo_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    assign stallE = muldiv_stallE | ext_stall;

    hilo_muldiv #(.DIV_ITERS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .aluopE       (aluopE),
        .srcaE        (srcaE),
        .srcbE        (srcbE),
        .stallE       (stallE),
        .cancelE      (cancelE),
        .muldiv_stallE(muldiv_stallE),
        .hilo_outE    (hilo_outE),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !stallE && (aluopE == OP_MFHI || aluopE == OP_MFLO)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got read of %h expected none", hilo_outE);
            end else begin
                chk(aluopE == OP_MFHI ? "mfhi" : "mflo", hilo_outE, exp_q.pop_front());
            end
        end
    end

    // Entered just after a rising edge; returns just after the edge that retires the op.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int cycles);
        aluopE = op;
        srcaE  = a;
        srcbE  = b;
        stalls = 0;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycles++;
            if (muldiv_stallE) stalls++;
            if (!stallE) break;
        end
        if (stallE) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got still stalled expected retire, op %h", op);
        end
        @(posedge clk);
        #1;
        aluopE = OP_NOP;
    endtask

    task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int s, c;
        exp_q.push_back(exp_hi);
        issue(OP_MFHI, 32'h0, 32'h0, s, c);
        exp_q.push_back(exp_lo);
        issue(OP_MFLO, 32'h0, 32'h0, s, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, c, n;
        rst = 1'b1; aluopE = OP_NOP; srcaE = 32'h0; srcbE = 32'h0;
        ext_stall = 1'b0; cancelE = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", hi_o, 32'h0);
        chk("reset_lo", lo_o, 32'h0);
        chk("reset_stall", {31'h0, muldiv_stallE}, 32'h0);
        chk("reset_hilo_out", hilo_outE, 32'h0);
        @(posedge clk);
        #1;

        read_hilo(32'h0, 32'h0);

        issue(OP_MTHI, 32'h1234_5678, 32'h0, s, c);
        chk("mthi_stalls", s, 0);
        read_hilo(32'h1234_5678, 32'h0);

        issue(OP_MULT, 32'hffff_ffff, 32'h2, s, c);
        chk("mult_stalls", s, MulStalls);
        read_hilo(32'hffff_ffff, 32'hffff_fffe);

        issue(OP_MULTU, 32'hffff_ffff, 32'h2, s, c);
        chk("multu_stalls", s, MulStalls);
        chk("multu_cycles", c, MulStalls + 1);
        read_hilo(32'h0000_0001, 32'hffff_fffe);

        issue(OP_DIV, 32'hffff_fff9, 32'h2, s, c);
        chk("div_stalls", s, 33);
        chk("div_cycles", c, 34);
        read_hilo(32'hffff_ffff, 32'hffff_fffd);

        issue(OP_DIVU, 32'd100, 32'h0, s, c);
        chk("divu0_cycles", c, 34);
        read_hilo(32'd100, 32'hffff_ffff);

        // Cancel during the tenth BUSY iteration.
        aluopE = OP_DIVU; srcaE = 32'd10; srcbE = 32'd3;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        cancelE = 1'b1;
        @(negedge clk);
        chk("busy_stall", {31'h0, muldiv_stallE}, 32'h1);
        @(posedge clk);
        #1 cancelE = 1'b0; aluopE = OP_NOP;
        @(negedge clk);
        chk("cancel_stall", {31'h0, muldiv_stallE}, 32'h0);
        chk("cancel_hi", hi_o, 32'd100);
        chk("cancel_lo", lo_o, 32'hffff_ffff);
        @(posedge clk);
        #1;
        issue(OP_DIVU, 32'd10, 32'd3, s, c);
        chk("divu_after_cancel_cycles", c, 34);
        read_hilo(32'd1, 32'd3);

        // DONE held by an external stall for five cycles.
        ext_stall = 1'b1;
        aluopE = OP_DIV; srcaE = 32'd100; srcbE = 32'hffff_fff9;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!muldiv_stallE) break;
            n++;
        end
        chk("held_div_stalls", n, 33);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("held_hi", hi_o, 32'd1);
            chk("held_lo", lo_o, 32'd3);
            chk("held_done_stall", {31'h0, muldiv_stallE}, 32'h0);
        end
        @(posedge clk);
        #1 ext_stall = 1'b0;
        @(negedge clk);
        chk("release_hi_pending", hi_o, 32'd1);
        @(posedge clk);
        #1 aluopE = OP_NOP;
        @(negedge clk);
        chk("release_hi", hi_o, 32'd2);
        chk("release_lo", lo_o, 32'hffff_fff2);
        chk("release_no_restart", {31'h0, muldiv_stallE}, 32'h0);
        @(posedge clk);
        #1;
        read_hilo(32'd2, 32'hffff_fff2);

        issue(OP_MTLO, 32'hdead_beef, 32'h0, s, c);
        read_hilo(32'd2, 32'hdead_beef);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
